// File: rtl/decoder_2ri12_pkg.sv
// Shared definitions for the 2RI12 decode stage: op codes, opcode field
// values, the per-lane decode record and small decode helpers.
package decoder_2ri12_pkg;

  // Decoded op codes. OP_INVALID is deliberately non-zero so an idle or
  // reset lane cannot be confused with an all-zero data word.
  localparam logic [7:0] OP_INVALID = 8'hFF;
  localparam logic [7:0] OP_SLTI    = 8'h01;
  localparam logic [7:0] OP_SLTUI   = 8'h02;
  localparam logic [7:0] OP_ADDI    = 8'h03;
  localparam logic [7:0] OP_ANDI    = 8'h04;
  localparam logic [7:0] OP_ORI     = 8'h05;
  localparam logic [7:0] OP_XORI    = 8'h06;
  localparam logic [7:0] OP_CACOP   = 8'h07;
  localparam logic [7:0] OP_LD      = 8'h08;
  localparam logic [7:0] OP_ST      = 8'h09;
  localparam logic [7:0] OP_LDU     = 8'h0A;

  // Full 10-bit opcode field values, inst[31:22].
  localparam logic [9:0] OPC_SLTI  = 10'b0000001000;
  localparam logic [9:0] OPC_SLTUI = 10'b0000001001;
  localparam logic [9:0] OPC_ADDI  = 10'b0000001010;
  localparam logic [9:0] OPC_ANDI  = 10'b0000001101;
  localparam logic [9:0] OPC_ORI   = 10'b0000001110;
  localparam logic [9:0] OPC_XORI  = 10'b0000001111;
  localparam logic [9:0] OPC_CACOP = 10'b0000011000;

  // Memory ops only decode inst[31:24]; inst[23:22] carries the access size.
  localparam logic [7:0] OPC_LD  = 8'b00101000;
  localparam logic [7:0] OPC_ST  = 8'b00101001;
  localparam logic [7:0] OPC_LDU = 8'b00101010;

  // Result of decoding one instruction.
  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [1:0]  msize;
    logic        ine;
  } lane_dec_t;

  // True for ops that carry an access size.
  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_LDU);
  endfunction

  // Extend the 12-bit immediate field to 32 bits.
  function automatic logic [31:0] ext_imm12(input logic [11:0] field, input logic zext);
    return zext ? {20'd0, field} : {{20{field[11]}}, field};
  endfunction

endpackage

// File: rtl/decoder_2ri12_lane.sv
// Combinational decoder for one 2RI12 instruction word.
module decoder_2ri12_lane
  import decoder_2ri12_pkg::*;
#(
  parameter bit EN_CACOP = 1'b1
) (
  input  logic [31:0] i_inst,
  input  logic        i_mask,
  output lane_dec_t   o_dec
);

  logic [7:0] w_op;
  logic       w_zext;

  // Map the opcode field to an op; memory ops are matched on the 8-bit prefix.
  always_comb begin
    w_op = OP_INVALID;
    case (i_inst[31:22])
      OPC_SLTI:  w_op = OP_SLTI;
      OPC_SLTUI: w_op = OP_SLTUI;
      OPC_ADDI:  w_op = OP_ADDI;
      OPC_ANDI:  w_op = OP_ANDI;
      OPC_ORI:   w_op = OP_ORI;
      OPC_XORI:  w_op = OP_XORI;
      OPC_CACOP: w_op = EN_CACOP ? OP_CACOP : OP_INVALID;
      default: begin
        case (i_inst[31:24])
          OPC_LD:  w_op = OP_LD;
          OPC_ST:  w_op = OP_ST;
          OPC_LDU: w_op = OP_LDU;
          default: w_op = OP_INVALID;
        endcase
      end
    endcase
  end

  // Only the logical ops treat their immediate as unsigned.
  always_comb begin
    w_zext = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);
  end

  // Assemble the lane result; masked-out lanes are forced to a quiet invalid.
  always_comb begin
    o_dec.op    = OP_INVALID;
    o_dec.imm   = 32'd0;
    o_dec.rd    = 5'd0;
    o_dec.rj    = 5'd0;
    o_dec.msize = 2'b00;
    o_dec.ine   = 1'b0;
    if (i_mask) begin
      o_dec.op    = w_op;
      o_dec.imm   = (w_op == OP_INVALID) ? 32'd0 : ext_imm12(i_inst[21:10], w_zext);
      o_dec.rd    = i_inst[4:0];
      o_dec.rj    = i_inst[9:5];
      o_dec.msize = is_mem_op(w_op) ? i_inst[23:22] : 2'b00;
      o_dec.ine   = (w_op == OP_INVALID);
    end
  end

endmodule

// File: rtl/decoder_2ri12_stage.sv
// Multi-lane 2RI12 decode stage: combinational lane decoders feeding an
// output register backed by a one-entry skid buffer (valid/ready handshake).
module decoder_2ri12_stage
  import decoder_2ri12_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int OP_W     = 8,
  parameter bit EN_CACOP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_inst,
  input  logic [LANES-1:0]      in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_mask,
  output logic [LANES*OP_W-1:0] out_op,
  output logic [LANES*32-1:0]   out_imm,
  output logic [LANES*5-1:0]    out_rd,
  output logic [LANES*5-1:0]    out_rj,
  output logic [LANES*2-1:0]    out_msize,
  output logic [LANES-1:0]      out_ine
);

  // Per-lane record layout inside the flat bundle, LSB first:
  // ine | msize | rj | rd | imm | op | mask
  localparam int LW       = 46 + OP_W;
  localparam int OFS_INE  = 0;
  localparam int OFS_MSZ  = 1;
  localparam int OFS_RJ   = 3;
  localparam int OFS_RD   = 8;
  localparam int OFS_IMM  = 13;
  localparam int OFS_OP   = 45;
  localparam int OFS_MASK = 45 + OP_W;
  localparam int BW       = LANES * LW;

  // Reset image: every lane invalid, all other fields zero.
  localparam logic [LW-1:0] RST_LANE   = {1'b0, OP_W'(OP_INVALID), 45'd0};
  localparam logic [BW-1:0] RST_BUNDLE = {LANES{RST_LANE}};

  logic [BW-1:0] w_in_bundle;
  logic [BW-1:0] r_out_bundle;
  logic [BW-1:0] r_skid_bundle;
  logic          r_out_valid;
  logic          r_skid_valid;
  logic          r_in_ready;

  logic          w_accept;
  logic          w_out_load;
  logic          w_to_skid;
  logic          w_skid_valid_next;

  // Decode each lane of the incoming group and pack it into the bundle.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_dec_t w_dec;

    decoder_2ri12_lane #(
      .EN_CACOP (EN_CACOP)
    ) u_lane (
      .i_inst (in_inst[32*gi +: 32]),
      .i_mask (in_mask[gi]),
      .o_dec  (w_dec)
    );

    assign w_in_bundle[gi*LW +: LW] = {in_mask[gi], OP_W'(w_dec.op), w_dec.imm,
                                       w_dec.rd, w_dec.rj, w_dec.msize, w_dec.ine};

    assign out_mask[gi]             = r_out_bundle[gi*LW + OFS_MASK];
    assign out_op[gi*OP_W +: OP_W]  = r_out_bundle[gi*LW + OFS_OP  +: OP_W];
    assign out_imm[gi*32 +: 32]     = r_out_bundle[gi*LW + OFS_IMM +: 32];
    assign out_rd[gi*5 +: 5]        = r_out_bundle[gi*LW + OFS_RD  +: 5];
    assign out_rj[gi*5 +: 5]        = r_out_bundle[gi*LW + OFS_RJ  +: 5];
    assign out_msize[gi*2 +: 2]     = r_out_bundle[gi*LW + OFS_MSZ +: 2];
    assign out_ine[gi]              = r_out_bundle[gi*LW + OFS_INE];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  // Handshake decisions for the current cycle.
  always_comb begin
    w_accept   = in_valid & r_in_ready;
    w_out_load = ~r_out_valid | out_ready;
    // An accepted group parks in the skid when the output cannot take it
    // directly, either because it is stalled or because the skid drains first.
    w_to_skid  = w_accept & (~w_out_load | r_skid_valid);
    w_skid_valid_next = w_to_skid | (r_skid_valid & ~w_out_load);
  end

  // Control state: output valid, skid occupancy and the registered in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_out_load) begin
        r_out_valid <= r_skid_valid | w_accept;
      end
      r_skid_valid <= w_skid_valid_next;
      r_in_ready   <= ~w_skid_valid_next;
    end
  end

  // Output data register: skid contents have priority over a new group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_bundle <= RST_BUNDLE;
    end else if (!flush && w_out_load) begin
      if (r_skid_valid) begin
        r_out_bundle <= r_skid_bundle;
      end else if (w_accept) begin
        r_out_bundle <= w_in_bundle;
      end
    end
  end

  // Skid data register: captures a group that could not go straight out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_bundle <= RST_BUNDLE;
    end else if (!flush && w_to_skid) begin
      r_skid_bundle <= w_in_bundle;
    end
  end

endmodule

// File: tb/tb_decoder_2ri12_stage.sv
// Testbench for decoder_2ri12_stage: a queue-based model of the stage's
// held groups plus a from-first-principles instruction decoder, checked
// every cycle, with directed scenarios and hand-computed literal checks.
module tb_decoder_2ri12_stage;
  import decoder_2ri12_pkg::*;

  localparam int LANES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_inst = 64'd0;
  logic [1:0]  in_mask = 2'b00;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [1:0]  out_mask_a, out_mask_b, out_ine_a, out_ine_b;
  logic [15:0] out_op_a, out_op_b;
  logic [63:0] out_imm_a, out_imm_b;
  logic [9:0]  out_rd_a, out_rd_b, out_rj_a, out_rj_b;
  logic [3:0]  out_msize_a, out_msize_b;

  decoder_2ri12_stage #(.LANES(LANES), .OP_W(8), .EN_CACOP(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_mask(in_mask), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_mask(out_mask_a), .out_op(out_op_a), .out_imm(out_imm_a), .out_rd(out_rd_a),
    .out_rj(out_rj_a), .out_msize(out_msize_a), .out_ine(out_ine_a)
  );

  decoder_2ri12_stage #(.LANES(LANES), .OP_W(8), .EN_CACOP(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_mask(in_mask), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_mask(out_mask_b), .out_op(out_op_b), .out_imm(out_imm_b), .out_rd(out_rd_b),
    .out_rj(out_rj_b), .out_msize(out_msize_b), .out_ine(out_ine_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] inst;
    logic [1:0]  mask;
  } grp_t;

  grp_t q[$];          // groups held by the stage, oldest first
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Expected lane result {op, imm, rd, rj, msize, ine} from the instruction rules.
  function automatic logic [52:0] exp_lane(input logic [31:0] inst, input logic m, input logic en_c);
    logic [7:0]  op;
    logic [31:0] imm;
    logic [1:0]  ms;
    int          top10, top8, f;
    if (!m) return {OP_INVALID, 45'd0};
    top10 = int'(inst[31:22]);
    top8  = int'(inst[31:24]);
    op    = OP_INVALID;
    ms    = 2'b00;
    if      (top10 == 8)  op = OP_SLTI;
    else if (top10 == 9)  op = OP_SLTUI;
    else if (top10 == 10) op = OP_ADDI;
    else if (top10 == 13) op = OP_ANDI;
    else if (top10 == 14) op = OP_ORI;
    else if (top10 == 15) op = OP_XORI;
    else if (top10 == 24) op = en_c ? OP_CACOP : OP_INVALID;
    else if (top8 == 'h28) begin op = OP_LD;  ms = inst[23:22]; end
    else if (top8 == 'h29) begin op = OP_ST;  ms = inst[23:22]; end
    else if (top8 == 'h2A) begin op = OP_LDU; ms = inst[23:22]; end
    f = int'(inst[21:10]);
    if (op == OP_INVALID) imm = 32'd0;
    else if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) imm = 32'(f);
    else if (f >= 2048) imm = 32'(f - 4096);
    else imm = 32'(f);
    return {op, imm, inst[4:0], inst[9:5], ms, (op == OP_INVALID)};
  endfunction

  function automatic logic [52:0] pack(input logic [15:0] op, input logic [63:0] imm,
                                       input logic [9:0] rd, input logic [9:0] rj,
                                       input logic [3:0] ms, input logic [1:0] ine, input int l);
    return {op[l*8 +: 8], imm[l*32 +: 32], rd[l*5 +: 5], rj[l*5 +: 5], ms[l*2 +: 2], ine[l]};
  endfunction

  // Model: the stage holds at most two groups and accepts while it holds fewer.
  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      q.delete();
    end else begin
      if (in_valid && q.size() < 2) begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        q.push_back('{inst: in_inst, mask: in_mask});
      end else if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
    chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
    chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_mask_a", 64'(out_mask_a), 64'(q[0].mask));
      chk("out_mask_b", 64'(out_mask_b), 64'(q[0].mask));
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("lane%0d_a", l),
            64'(pack(out_op_a, out_imm_a, out_rd_a, out_rj_a, out_msize_a, out_ine_a, l)),
            64'(exp_lane(q[0].inst[l*32 +: 32], q[0].mask[l], 1'b1)));
        chk($sformatf("lane%0d_b", l),
            64'(pack(out_op_b, out_imm_b, out_rd_b, out_rj_b, out_msize_b, out_ine_b, l)),
            64'(exp_lane(q[0].inst[l*32 +: 32], q[0].mask[l], 1'b0)));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] m, input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = {i1, i0};
    in_mask   = m;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("txn t=%0t v=%0d inst=%h mask=%b rdy=%0d fl=%0d -> ov=%0d ir=%0d op=%h imm=%h",
             $time, v, {i1, i0}, m, rdy, fl, out_valid_a, in_ready_a, out_op_a, out_imm_a);
  endtask

  logic [31:0] tbl [8] = '{32'h02BFFC41, 32'h03A00063, 32'h28800000, 32'hFFFFFFFF,
                           32'h06000000, 32'h037FFC00, 32'h29000000, 32'h2A4FFC85};

  initial begin
    // Pin the model against hand-decoded words.
    chk("pin_addi",  64'(exp_lane(32'h02BFFC41, 1'b1, 1'b1)),
        64'({OP_ADDI, 32'hFFFFFFFF, 5'd1, 5'd2, 2'b00, 1'b0}));
    chk("pin_ori",   64'(exp_lane(32'h03A00063, 1'b1, 1'b1)),
        64'({OP_ORI, 32'h00000800, 5'd3, 5'd3, 2'b00, 1'b0}));
    chk("pin_ld",    64'(exp_lane(32'h28800000, 1'b1, 1'b1)),
        64'({OP_LD, 32'd0, 5'd0, 5'd0, 2'b10, 1'b0}));
    chk("pin_bad",   64'(exp_lane(32'hFFFFFFFF, 1'b1, 1'b1)),
        64'({OP_INVALID, 32'd0, 5'd31, 5'd31, 2'b00, 1'b1}));
    chk("pin_cacop_off", 64'(exp_lane(32'h06000000, 1'b1, 1'b0)),
        64'({OP_INVALID, 32'd0, 5'd0, 5'd0, 2'b00, 1'b1}));
    chk("pin_masked", 64'(exp_lane(32'h02BFFC41, 1'b0, 1'b1)),
        64'({OP_INVALID, 45'd0}));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready",  64'(in_ready_a), 64'd1);
    chk("rst_out_op",    64'(out_op_a), 64'h0000_0000_0000_FFFF);
    chk("rst_out_imm",   out_imm_a, 64'd0);
    chk("rst_out_ine",   64'(out_ine_a), 64'd0);
    reset = 1'b0;

    // ADDI r1,r2,-1 with lane 1 masked out; one cycle latency.
    drive(1'b1, 32'h02BFFC41, 32'h0, 2'b01, 1'b1, 1'b0);
    chk("t1_valid", 64'(out_valid_a), 64'd1);
    chk("t1_op",    64'(out_op_a[7:0]), 64'(OP_ADDI));
    chk("t1_imm",   64'(out_imm_a[31:0]), 64'hFFFFFFFF);
    chk("t1_rd_rj", 64'({out_rd_a[4:0], out_rj_a[4:0]}), 64'({5'd1, 5'd2}));
    chk("t1_lane1", 64'({out_op_a[15:8], out_ine_a}), 64'({OP_INVALID, 2'b00}));

    // ORI zero-extension.
    drive(1'b1, 32'h03A00063, 32'h0, 2'b01, 1'b1, 1'b0);
    chk("t2_op",  64'(out_op_a[7:0]), 64'(OP_ORI));
    chk("t2_imm", 64'(out_imm_a[31:0]), 64'h00000800);
    chk("t2_ine", 64'(out_ine_a[0]), 64'd0);

    // LD.W plus an undefined word in lane 1.
    drive(1'b1, 32'h28800000, 32'hFFFFFFFF, 2'b11, 1'b1, 1'b0);
    chk("t3_op0",   64'(out_op_a[7:0]), 64'(OP_LD));
    chk("t3_msize", 64'(out_msize_a[1:0]), 64'd2);
    chk("t3_op1",   64'(out_op_a[15:8]), 64'(OP_INVALID));
    chk("t3_ine1",  64'(out_ine_a[1]), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("t3_drain", 64'(out_valid_a), 64'd0);

    // Backpressure for 3 cycles with back-to-back groups.
    drive(1'b1, 32'h02BFFC41, 32'h0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 32'h03A00063, 32'h0, 2'b01, 1'b0, 1'b0);
    chk("t4_ready_low", 64'(in_ready_a), 64'd0);
    chk("t4_hold_a",    64'(out_imm_a[31:0]), 64'hFFFFFFFF);
    drive(1'b1, 32'h28800000, 32'h0, 2'b01, 1'b0, 1'b0);
    chk("t4_hold_a2",   64'(out_op_a[7:0]), 64'(OP_ADDI));
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("t4_second",    64'({out_valid_a, out_op_a[7:0]}), 64'({1'b1, OP_ORI}));
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("t4_empty",     64'(out_valid_a), 64'd0);

    // Flush with output and skid both full and a new group presented.
    drive(1'b1, 32'h02BFFC41, 32'h0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 32'h03A00063, 32'h0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 32'h28800000, 32'h0, 2'b01, 1'b0, 1'b1);
    chk("t5_valid", 64'(out_valid_a), 64'd0);
    chk("t5_ready", 64'(in_ready_a), 64'd1);
    repeat (3) drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("t5_none",  64'(out_valid_a), 64'd0);

    // CACOP enabled vs disabled, then asynchronous reset mid-transfer.
    drive(1'b1, 32'h06000000, 32'h0, 2'b01, 1'b0, 1'b0);
    chk("t6_cacop_a", 64'({out_op_a[7:0], out_ine_a[0]}), 64'({OP_CACOP, 1'b0}));
    chk("t6_cacop_b", 64'({out_op_b[7:0], out_ine_b[0], out_imm_b[31:0]}),
        64'({OP_INVALID, 1'b1, 32'd0}));
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_a", 64'(out_valid_a), 64'd0);
    chk("t6_async_b", 64'(out_valid_b), 64'd0);
    chk("t6_async_op", 64'(out_op_a), 64'h0000_0000_0000_FFFF);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Mixed traffic with random valid/ready/flush over a directed word table.
    for (int n = 0; n < 80; n++) begin
      drive(1'($urandom_range(0, 1)), tbl[$urandom_range(0, 7)], tbl[$urandom_range(0, 7)],
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0));
    end
    repeat (3) drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
